// File: rtl/pacote_controle.sv
// Shared definitions for the multicycle control unit: opcodes, state encoding
// and the decode table that yields the static datapath selects.
package pacote_controle;

  localparam int LARG_ESPERA = 4;

  localparam logic [5:0] OP_R       = 6'b000000;
  localparam logic [5:0] OP_SLL_SRL = 6'b100000;
  localparam logic [5:0] OP_SLA     = 6'b100001;
  localparam logic [5:0] OP_SRA     = 6'b100010;
  localparam logic [5:0] OP_ADDI    = 6'b000001;
  localparam logic [5:0] OP_SUBI    = 6'b000010;
  localparam logic [5:0] OP_LW      = 6'b000011;
  localparam logic [5:0] OP_SW      = 6'b000100;
  localparam logic [5:0] OP_ANDI    = 6'b000101;
  localparam logic [5:0] OP_ORI     = 6'b000110;
  localparam logic [5:0] OP_MOV     = 6'b000111;
  localparam logic [5:0] OP_LUI     = 6'b001000;
  localparam logic [5:0] OP_BEQ     = 6'b001001;
  localparam logic [5:0] OP_BNE     = 6'b001010;
  localparam logic [5:0] OP_SLTI    = 6'b001011;
  localparam logic [5:0] OP_J       = 6'b001100;
  localparam logic [5:0] OP_JR      = 6'b001101;
  localparam logic [5:0] OP_IN      = 6'b001110;
  localparam logic [5:0] OP_OUT     = 6'b001111;
  localparam logic [5:0] OP_NOP     = 6'b010000;
  localparam logic [5:0] OP_HALT    = 6'b010001;
  localparam logic [5:0] OP_JAL     = 6'b010010;

  // ULA_FUNCT tells the ALU to take its operation from the R-type funct field
  localparam logic [3:0] ULA_ADD   = 4'b0000;
  localparam logic [3:0] ULA_SUB   = 4'b0001;
  localparam logic [3:0] ULA_AND   = 4'b0010;
  localparam logic [3:0] ULA_OR    = 4'b0011;
  localparam logic [3:0] ULA_SLT   = 4'b0100;
  localparam logic [3:0] ULA_SHL   = 4'b0101;
  localparam logic [3:0] ULA_SLA   = 4'b0110;
  localparam logic [3:0] ULA_SRA   = 4'b0111;
  localparam logic [3:0] ULA_LUI   = 4'b1000;
  localparam logic [3:0] ULA_FUNCT = 4'b1001;
  localparam logic [3:0] ULA_NOP   = 4'b1111;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    ESPERA_IN  = 3'd5,
    PARADO     = 3'd6
  } estado_t;

  typedef struct packed {
    logic [3:0] opula;
    logic       origula;
    logic       opshamt;
    logic       opmov;
    logic       reglei2;
    logic       memparareg;
    logic       jal;
    logic       jr;
  } selecao_t;

  localparam selecao_t SEL_NOP = '{ULA_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic selecao_t decodifica(input logic [5:0] op);
    selecao_t s;
    s = SEL_NOP;
    case (op)
      OP_R:       s.opula = ULA_FUNCT;
      OP_SLL_SRL: begin s.opula = ULA_SHL;  s.opshamt = 1'b1; end
      OP_SLA:     begin s.opula = ULA_SLA;  s.opshamt = 1'b1; end
      OP_SRA:     begin s.opula = ULA_SRA;  s.opshamt = 1'b1; end
      OP_ADDI:    begin s.opula = ULA_ADD;  s.origula = 1'b1; end
      OP_SUBI:    begin s.opula = ULA_SUB;  s.origula = 1'b1; end
      OP_LW:      begin s.opula = ULA_ADD;  s.origula = 1'b1; s.memparareg = 1'b1; end
      OP_SW:      begin s.opula = ULA_ADD;  s.origula = 1'b1; s.reglei2 = 1'b1; end
      OP_ANDI:    begin s.opula = ULA_AND;  s.origula = 1'b1; end
      OP_ORI:     begin s.opula = ULA_OR;   s.origula = 1'b1; end
      OP_MOV:     begin s.opula = ULA_ADD;  s.opmov = 1'b1; end
      OP_LUI:     begin s.opula = ULA_LUI;  s.origula = 1'b1; end
      OP_BEQ,
      OP_BNE:     s.opula = ULA_SUB;
      OP_SLTI:    begin s.opula = ULA_SLT;  s.origula = 1'b1; end
      OP_JR:      s.jr = 1'b1;
      OP_JAL:     s.jal = 1'b1;
      default:    ;
    endcase
    return s;
  endfunction

  // True for every opcode that needs the EXECUTA state; nop, halt and unknowns are false
  function automatic logic opcode_executavel(input logic [5:0] op);
    case (op)
      OP_R, OP_SLL_SRL, OP_SLA, OP_SRA, OP_ADDI, OP_SUBI, OP_LW, OP_SW,
      OP_ANDI, OP_ORI, OP_MOV, OP_LUI, OP_BEQ, OP_BNE, OP_SLTI, OP_J,
      OP_JR, OP_IN, OP_OUT, OP_JAL: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Wait-state counter shared by BUSCA and MEMORIA: counts cycles spent in the
// current state and flags the first and the last (LIMITE-th) cycle.
module contador_espera
  import pacote_controle::*;
#(
  parameter int LIMITE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic primeiro,
  output logic pronto
);

  localparam logic [LARG_ESPERA-1:0] ALVO = LARG_ESPERA'(LIMITE);

  logic [LARG_ESPERA-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      contagem <= '0;
    else if (limpa) contagem <= '0;
    else            contagem <= contagem + 1'b1;
  end

  assign primeiro = (contagem == '0);
  assign pronto   = (contagem == ALVO);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: sequences fetch, decode, execute, memory and write-back.
// Define CONTADOR_INSTR_EN to build the retired-instruction counter.
module unidade_controle_multiciclo
  import pacote_controle::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ULAOP_W  = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                entrada_pronta,
  input  logic                continuar,
  output logic                EscrevePC,
  output logic                EscreveIR,
  output logic                Jal,
  output logic                Jr,
  output logic                Jump,
  output logic                Branch,
  output logic                BranchNE,
  output logic                MemparaReg,
  output logic                OrigULA,
  output logic                OpShamt,
  output logic                OpMov,
  output logic                RegLei2,
  output logic [ULAOP_W-1:0]  OpULA,
  output logic                EscreveMem,
  output logic                EscreveReg,
  output logic                OpIn,
  output logic                OpOut,
  output logic                OpHalt,
  output logic [2:0]          estado,
  output logic [31:0]         instr_retiradas
);

  estado_t    estado_atual, proximo;
  logic [5:0] op_ir, op_lat;
  selecao_t   sel;
  logic       espera_limpa, espera_primeiro, espera_pronto;

  assign op_ir = 6'(opcode);

  contador_espera #(.LIMITE(MEM_WAIT)) u_espera (
    .clock    (clock),
    .reset    (reset),
    .limpa    (espera_limpa),
    .primeiro (espera_primeiro),
    .pronto   (espera_pronto)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_atual <= BUSCA;
    else       estado_atual <= proximo;
  end

  // The IR may change after decode, so later states work from this copy
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           op_lat <= OP_NOP;
    else if (estado_atual == DECODIFICA) op_lat <= op_ir;
  end

  always_comb begin
    proximo      = estado_atual;
    sel          = SEL_NOP;
    espera_limpa = 1'b1;
    EscrevePC    = 1'b0;
    EscreveIR    = 1'b0;
    Jump         = 1'b0;
    Branch       = 1'b0;
    BranchNE     = 1'b0;
    EscreveMem   = 1'b0;
    EscreveReg   = 1'b0;
    OpIn         = 1'b0;
    OpOut        = 1'b0;
    OpHalt       = 1'b0;
    case (estado_atual)
      BUSCA: begin
        espera_limpa = espera_pronto;
        if (espera_pronto) begin
          EscreveIR = 1'b1;
          EscrevePC = 1'b1;
          proximo   = DECODIFICA;
        end
      end
      DECODIFICA: begin
        if (op_ir == OP_HALT)              proximo = PARADO;
        else if (opcode_executavel(op_ir)) proximo = EXECUTA;
        else                               proximo = BUSCA;
      end
      EXECUTA: begin
        sel     = decodifica(op_lat);
        proximo = BUSCA;
        case (op_lat)
          OP_BEQ:       Branch = 1'b1;
          OP_BNE:       BranchNE = 1'b1;
          OP_J:         begin Jump = 1'b1; EscrevePC = 1'b1; end
          OP_JR:        EscrevePC = 1'b1;
          OP_JAL:       begin EscrevePC = 1'b1; proximo = ESCRITA; end
          OP_LW, OP_SW: proximo = MEMORIA;
          OP_IN:        proximo = ESPERA_IN;
          OP_OUT:       OpOut = 1'b1;
          default:      proximo = ESCRITA;
        endcase
      end
      MEMORIA: begin
        sel          = decodifica(op_lat);
        espera_limpa = espera_pronto;
        EscreveMem   = (op_lat == OP_SW) && espera_primeiro;
        if (espera_pronto) proximo = (op_lat == OP_SW) ? BUSCA : ESCRITA;
      end
      ESCRITA: begin
        sel        = decodifica(op_lat);
        EscreveReg = 1'b1;
        proximo    = BUSCA;
      end
      ESPERA_IN: begin
        sel  = decodifica(op_lat);
        OpIn = 1'b1;
        if (entrada_pronta) begin
          EscreveReg = 1'b1;
          proximo    = BUSCA;
        end
      end
      PARADO: begin
        OpHalt = 1'b1;
        if (continuar) proximo = BUSCA;
      end
      default: proximo = BUSCA;
    endcase
  end

  assign OpULA      = ULAOP_W'(sel.opula);
  assign OrigULA    = sel.origula;
  assign OpShamt    = sel.opshamt;
  assign OpMov      = sel.opmov;
  assign RegLei2    = sel.reglei2;
  assign MemparaReg = sel.memparareg;
  assign Jal        = sel.jal;
  assign Jr         = sel.jr;
  assign estado     = estado_atual;

`ifdef CONTADOR_INSTR_EN
  logic [31:0] contador_instr;
  logic        retira;

  // Leaving PARADO does not retire anything, so it is excluded here
  assign retira = (proximo == BUSCA) &&
                  (estado_atual inside {DECODIFICA, EXECUTA, MEMORIA, ESCRITA, ESPERA_IN});

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       contador_instr <= '0;
    else if (retira) contador_instr <= contador_instr + 32'd1;
  end

  assign instr_retiradas = contador_instr;
`else
  assign instr_retiradas = 32'd0;
`endif

endmodule
